itof_pipe: RTL and testbench
============================

// Module: itof_pipe
// PURPOSE
// - Converts a signed 32-bit two's-complement integer to an IEEE-754 single; inverse of the FPU's float->int path.
// - 3-stage pipeline with valid/ready handshakes on input and output; sits in the FPU issue path beside ftoi.
// - Full throughput: one conversion per cycle when downstream is ready.
// PARAMETERS
// - TIES_EVEN  1  1: round-to-nearest, ties-to-even; 0: round-to-nearest, ties-away-from-zero (ftoi convention)
// PORTS
// - clk        in   1   clock, rising edge
// - rst        in   1   asynchronous reset, active-high
// - in_valid   in   1   a is valid
// - in_ready   out  1   block accepts a this cycle
// - a          in   32  signed integer operand
// - out_valid  out  1   y is valid
// - out_ready  in   1   downstream accepts y this cycle
// - y          out  32  IEEE-754 single result {s, e[7:0], m[22:0]}
// - inexact    out  1   only with ITOF_INEXACT_EN; see CONFIGURATION
// BEHAVIOUR
// - Reset: all stage valids 0, so out_valid=0 and y=0 (plus inexact=0). Data registers clear to 0.
// - Reset mid-operation drops all in-flight items; nothing is emitted after release until new input.
// - Transfer: in on in_valid&in_ready; out on out_valid&out_ready.
// - Stall chain: stage k advances iff its successor is empty or advancing.
//   - in_ready = !v1 | adv1.
//   - in_ready is combinational from out_ready, with no register bubble; 3 items are held under stall.
// - Latency: 3 cycles from accept to out_valid with out_ready held high. Order preserved. No drop, no duplicate.
// - While out_valid=1 and out_ready=0: y (and inexact) held stable.
// - S1: s=a[31]; mag = s ? -a : a (33-bit safe). a=32'h80000000 gives mag=2^31.
// - S2: lz = leading-zero count of 32-bit mag; norm = mag << lz (bit31 = hidden 1); zero flag if mag==0.
// - S3 rounding and pack:
//   - frac = norm[30:8]; G = norm[7]; sticky = |norm[6:0].
//   - TIES_EVEN=1: inc = G & (sticky | frac[0]).
//   - TIES_EVEN=0: inc = G.
//   - Mantissa add is 24-bit {1,frac}+inc. On carry-out: exponent+1, mantissa = 0.
//   - Exponent = 158 - lz (+1 on carry). Max is 158 (2^31), so no overflow or Inf is possible.
//   - Zero input: y = 32'h00000000 (positive zero); no negative zero is ever produced.
// - Magnitudes < 2^24 are exact (G = sticky = 0).
// CONFIGURATION
// - ITOF_INEXACT_EN defined:
//   - Adds output port inexact, registered in S3 and pipelined alongside y.
//   - inexact = G | sticky for the emitted item; valid only while out_valid=1.
// - ITOF_INEXACT_EN undefined: port absent; S3 computes no flag. All other behaviour is identical.
// TESTING
// - a=0, 1, -1 back-to-back, out_ready=1 -> y=00000000, 3F800000, BF800000 on 3 consecutive cycles; first at accept+3.
// - a=32'h80000000 -> y=CF000000; a=32'h7FFFFFFF -> y=4F000000 (round carry bumps exponent); inexact=1 when enabled.
// - Tie case a=16777217 (0x01000001):
//   - TIES_EVEN=1 -> y=4B800000.
//   - TIES_EVEN=0 -> y=4B800001.
//   - a=16777219 -> y=4B800002 in both modes.
// - Backpressure: stream 5 inputs while out_ready=0.
//   - Exactly 3 are accepted, then in_ready=0; y stays stable.
//   - Release out_ready -> all 5 emerge in order with no gap.
// - Reset asserted with 2 items in flight -> out_valid drops to 0 asynchronously; no stale output after release.
// - Random 10k signed ints with random valid/ready -> y matches a $bitstoshortreal-based reference model for the chosen TIES_EVEN; count in == count out.

Source files
------------

// File: rtl/itof_pipe.sv
// itof_pipe: 3-stage signed int32 -> IEEE-754 single converter with valid/ready flow control.
// Define ITOF_INEXACT_EN to add the registered inexact output pipelined alongside y.
module itof_pipe #(
  parameter int TIES_EVEN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
`ifdef ITOF_INEXACT_EN
  ,
  output logic        inexact
`endif
);

  function automatic logic [5:0] lzc32(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd32;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(31 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Only frac takes the increment: a carry out of frac is exactly a carry out of {1,frac},
  // and it leaves the stored mantissa at zero as required for the bumped exponent.
  function automatic logic [31:0] round_pack(input logic        s,
                                             input logic [31:0] norm,
                                             input logic [5:0]  lz);
    logic [22:0] frac;
    logic        g;
    logic        sticky;
    logic        inc;
    logic [23:0] sum;
    logic [7:0]  e;
    frac   = norm[30:8];
    g      = norm[7];
    sticky = |norm[6:0];
    if (TIES_EVEN != 0) inc = g & (sticky | frac[0]);
    else                inc = g;
    sum = {1'b0, frac} + {23'd0, inc};
    e   = 8'd158 - {2'b00, lz} + {7'd0, sum[23]};
    return norm[31] ? {s, e, sum[22:0]} : 32'd0;
  endfunction

  logic               vld_p1_q, vld_p2_q, vld_p3_q;
  logic               ld1, ld2, ld3;
  logic               s_p1_q, s_p2_q;
  logic signed [31:0] a_s;
  logic        [31:0] mag_p1_d, mag_p1_q;
  logic        [5:0]  lz_p2_d, lz_p2_q;
  logic        [31:0] norm_p2_d, norm_p2_q;
  logic        [31:0] y_p3_d, y_p3_q;

  assign ld3      = !vld_p3_q | out_ready;
  assign ld2      = !vld_p2_q | ld3;
  assign ld1      = !vld_p1_q | ld2;
  assign in_ready = ld1;

  // Stage 1: sign and magnitude; -32'h80000000 wraps to 32'h80000000, which read unsigned is 2^31.
  assign a_s      = a;
  assign mag_p1_d = a_s[31] ? unsigned'(-a_s) : unsigned'(a_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      s_p1_q   <= 1'b0;
      mag_p1_q <= 32'd0;
    end else begin
      if (ld1) vld_p1_q <= in_valid;
      if (ld1 && in_valid) begin
        s_p1_q   <= a_s[31];
        mag_p1_q <= mag_p1_d;
      end
    end
  end

  // Stage 2: normalise so the hidden one lands in bit 31; a zero magnitude stays all-zero.
  assign lz_p2_d   = lzc32(mag_p1_q);
  assign norm_p2_d = mag_p1_q << lz_p2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      s_p2_q    <= 1'b0;
      lz_p2_q   <= 6'd0;
      norm_p2_q <= 32'd0;
    end else begin
      if (ld2) vld_p2_q <= vld_p1_q;
      if (ld2 && vld_p1_q) begin
        s_p2_q    <= s_p1_q;
        lz_p2_q   <= lz_p2_d;
        norm_p2_q <= norm_p2_d;
      end
    end
  end

  // Stage 3: round and pack; contents hold while the consumer stalls.
  assign y_p3_d = round_pack(s_p2_q, norm_p2_q, lz_p2_q);

`ifdef ITOF_INEXACT_EN
  logic inexact_p3_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    inexact_p3_q <= 1'b0;
    else if (ld3 && vld_p2_q)   inexact_p3_q <= |norm_p2_q[7:0];
  end
  assign inexact = inexact_p3_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3_q <= 1'b0;
      y_p3_q   <= 32'd0;
    end else begin
      if (ld3) vld_p3_q <= vld_p2_q;
      if (ld3 && vld_p2_q) y_p3_q <= y_p3_d;
    end
  end

  assign out_valid = vld_p3_q;
  assign y         = y_p3_q;

endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: directed corner cases, backpressure, async reset and a random stream
// scored against an arithmetic int->single rounding model.
module tb_itof_pipe;
  localparam int TIES_EVEN = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
`ifdef ITOF_INEXACT_EN
  logic        inexact;
`endif

  itof_pipe #(.TIES_EVEN(TIES_EVEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
`ifdef ITOF_INEXACT_EN
    , .inexact(inexact)
`endif
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_in     = 0;
  int          n_out    = 0;
  logic [32:0] expq[$];
  logic [32:0] cur_exp;
  bit          acc, fire, ov_s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] obs_now();
`ifdef ITOF_INEXACT_EN
    return {inexact, y};
`else
    return {1'b0, y};
`endif
  endfunction

  function automatic logic [32:0] mask_exp(input logic [32:0] e);
    logic [32:0] r;
    r = e;
`ifndef ITOF_INEXACT_EN
    r[32] = 1'b0;
`endif
    return r;
  endfunction

  // Reference: find the binade, divide by the ulp, round the remainder by the chosen tie rule.
  function automatic logic [32:0] ref_itof(input logic [31:0] av);
    longint mag, q, rem, ulp, half;
    int     e;
    bit     s, up, inex;
    mag = longint'($signed(av));
    s   = (mag < 0);
    if (s) mag = -mag;
    if (mag == 0) return 33'd0;
    e = 31;
    while (mag < (longint'(1) << e)) e--;
    if (e <= 23) begin
      q    = mag << (23 - e);
      inex = 1'b0;
    end else begin
      ulp  = longint'(1) << (e - 23);
      half = ulp / 2;
      q    = mag / ulp;
      rem  = mag % ulp;
      inex = (rem != 0);
      up   = (rem > half) || (rem == half && (TIES_EVEN == 0 || (q % 2) == 1));
      if (up) q++;
      if (q == (longint'(1) << 24)) begin
        q = longint'(1) << 23;
        e++;
      end
    end
    return {inex, s, 8'(e + 127), 23'(q - (longint'(1) << 23))};
  endfunction

  function automatic logic [31:0] rand_a();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = $urandom;
      1: r = 32'($urandom_range(0, 2000)) - 32'd1000;
      2: r = 32'h0100_0000 + 32'($urandom_range(0, 4095));
      default: begin
        r = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) r = -r;
      end
    endcase
    return r;
  endfunction

  // One clock: sample handshakes on the falling edge, score any output, return 1ns after rise.
  task automatic step();
    logic [32:0] e;
    @(negedge clk);
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    ov_s = out_valid;
    if (acc) begin
      expq.push_back(cur_exp);
      n_in++;
    end
    if (fire) begin
      n_out++;
      check("out_not_before_in", 64'(n_out <= n_in), 64'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("y", 64'(obs_now()), 64'(mask_exp(e)));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < budget && expq.size() > 0; c++) step();
    check("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] bb_a[3];
    logic [32:0] bb_e[3];
    logic [31:0] dt_a[4];
    logic [32:0] dt_e[4];
    logic [31:0] bp_a[5];
    logic [32:0] tmp;
    int          idx, fired, gaps;
    bit          started;

    rst = 1'b1; in_valid = 1'b0; a = 32'd0; out_ready = 1'b0; cur_exp = 33'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(obs_now()), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 0, 1, -1 back to back: outputs on cycles 3..5 after the first accept cycle
    bb_a = '{32'd0, 32'd1, 32'hFFFF_FFFF};
    bb_e = '{33'h0_0000_0000, 33'h0_3F80_0000, 33'h0_BF80_0000};
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 3);
      a        = (c < 3) ? bb_a[c] : 32'd0;
      cur_exp  = (c < 3) ? bb_e[c] : 33'd0;
      step();
      check("bb_latency", 64'(ov_s), 64'(c >= 3 && c <= 5));
    end

    // Range ends, rounding carry and tie behaviour
    dt_a = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0100_0001, 32'h0100_0003};
    dt_e = '{33'h0_CF00_0000, 33'h1_4F00_0000,
             (TIES_EVEN != 0) ? 33'h1_4B80_0000 : 33'h1_4B80_0001, 33'h1_4B80_0002};
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      in_valid = 1'b1;
      a        = dt_a[idx];
      cur_exp  = dt_e[idx];
      step();
      if (acc) idx++;
    end
    check("dt_all_accepted", 64'(idx), 64'd4);
    drain(20);

    // Backpressure: three items fill the pipe, the rest wait for out_ready
    bp_a = '{32'd3, 32'hFFFF_FFF9, 32'd100000, 32'h4000_0001, 32'h7654_3211};
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 5);
      a        = (idx < 5) ? bp_a[idx] : 32'd0;
      cur_exp  = ref_itof(a);
      step();
      if (acc) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd3);
    tmp = ref_itof(bp_a[0]);
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_stall_valid", 64'(out_valid), 64'd1);
      check("bp_stall_y", 64'(y), 64'(tmp[31:0]));
      check("bp_stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    fired = 0; gaps = 0; started = 1'b0;
    for (int c = 0; c < 12 && fired < 5; c++) begin
      in_valid = (idx < 5);
      a        = (idx < 5) ? bp_a[idx] : 32'd0;
      cur_exp  = ref_itof(a);
      step();
      if (acc) idx++;
      if (fire) begin
        fired++;
        started = 1'b1;
      end else if (started) gaps++;
    end
    check("bp_all_out", 64'(fired), 64'd5);
    check("bp_no_gap", 64'(gaps), 64'd0);
    check("bp_all_in", 64'(idx), 64'd5);

    // Asynchronous reset with two items in flight
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      a        = 32'd1000 + 32'(c);
      cur_exp  = ref_itof(a);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_y", 64'(obs_now()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    n_in = 0;
    n_out = 0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("post_rst_idle", 64'(ov_s), 64'd0);
    end

    // Random stream with random valid/ready
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = rand_a();
      cur_exp   = ref_itof(a);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain(50);
    check("count_in_eq_out", 64'(n_in), 64'(n_out));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
